// File: rtl/riscv_icache_assoc.sv
// riscv_icache_assoc: N-way set-associative instruction cache with tree-PLRU
// replacement, block-spanning fetches, req/ack refill and fence.i flush.
module riscv_icache_assoc #(
    parameter int DATA_WIDTH = 128,
    parameter int MEM_SIZE   = 16*(2**20),
    parameter int CACHE_SIZE = 4*(2**10),
    parameter int WAYS       = 2,
    localparam int BLOCK_BYTES = DATA_WIDTH/8,
    localparam int ADDR        = $clog2(MEM_SIZE),
    localparam int SETS        = CACHE_SIZE/(BLOCK_BYTES*WAYS),
    localparam int BYTE_OFF    = $clog2(BLOCK_BYTES),
    localparam int INDEX       = $clog2(SETS),
    localparam int TAG         = ADDR-BYTE_OFF-INDEX,
    localparam int BADDR       = ADDR-BYTE_OFF
) (
    input  logic                  i_riscv_icache_clk,
    input  logic                  i_riscv_icache_rst,
    input  logic                  i_riscv_icache_req,
    input  logic [63:0]           i_riscv_icache_phys_addr,
    input  logic                  i_riscv_icache_flush,
    output logic [31:0]           o_riscv_icache_instr,
    output logic                  o_riscv_icache_stall,
    output logic                  o_riscv_icache_mem_req,
    output logic [BADDR-1:0]      o_riscv_icache_mem_addr,
    input  logic                  i_riscv_icache_mem_ack,
    input  logic [DATA_WIDTH-1:0] i_riscv_icache_mem_data
);
    localparam int PW = WAYS > 1 ? WAYS-1 : 1;
    localparam int WW = WAYS > 1 ? $clog2(WAYS) : 1;

    typedef enum logic [1:0] {IDLE, REFILL_LO, REFILL_HI, FLUSH} state_t;

    // Tree PLRU: each node bit points toward the less recently used half.
    function automatic logic [PW-1:0] plru_touch(input logic [PW-1:0] p, input logic [WW-1:0] w);
        logic [PW-1:0] r;
        r = p;
        if (WAYS == 2) r[0] = ~w[0];
        else if (WAYS == 4) begin
            r[0] = ~w[WW-1];
            r[32'(w[WW-1]) + 1] = ~w[0];
        end
        return r;
    endfunction

    function automatic logic [WW-1:0] victim(input logic [WAYS-1:0] v, input logic [PW-1:0] p);
        logic [WW-1:0] r;
        r = '0;
        if (WAYS == 2) r = WW'(p[0]);
        else if (WAYS == 4) r = WW'({p[0], p[32'(p[0]) + 1]});
        for (int w = WAYS-1; w >= 0; w--)
            if (!v[w]) r = WW'(w);
        return r;
    endfunction

    logic [DATA_WIDTH-1:0] data_q [WAYS][SETS];
    logic [TAG-1:0]        tag_q  [WAYS][SETS];
    logic [WAYS-1:0]       valid_q [SETS];
    logic [PW-1:0]         plru_q  [SETS];
    state_t                state_q, state_d;
    logic                  pend_q, pend_d;
    logic [BADDR-1:0]      maddr_q, maddr_d;

    logic [ADDR-1:0]       addr;
    logic [BADDR-1:0]      lo_b, hi_b;
    logic [INDEX-1:0]      lo_idx, hi_idx, r_idx;
    logic [TAG-1:0]        lo_tag, hi_tag, r_tag;
    logic [BYTE_OFF-1:0]   off;
    logic [WAYS-1:0]       lo_hits, hi_hits;
    logic [WW-1:0]         lo_way, hi_way, vic;
    logic [DATA_WIDTH-1:0] lo_data, hi_data;
    logic [2*DATA_WIDTH-1:0] pair;
    logic                  span, lo_hit, hi_ok, miss, refilling, refill_we, hit_upd;
    logic                  unused_addr;

    assign addr        = i_riscv_icache_phys_addr[ADDR-1:0];
    assign unused_addr = ^i_riscv_icache_phys_addr[63:ADDR];
    assign lo_b        = addr[ADDR-1:BYTE_OFF];
    assign hi_b        = lo_b + 1'b1;
    assign {lo_tag, lo_idx} = lo_b;
    assign {hi_tag, hi_idx} = hi_b;
    assign {r_tag, r_idx}   = maddr_q;
    assign off         = addr[BYTE_OFF-1:0];
    assign span        = off > BYTE_OFF'(BLOCK_BYTES-4);

    always_comb begin
        lo_hits = '0;
        hi_hits = '0;
        lo_way  = '0;
        hi_way  = '0;
        lo_data = '0;
        hi_data = '0;
        for (int w = 0; w < WAYS; w++) begin
            lo_hits[w] = valid_q[lo_idx][w] && (tag_q[w][lo_idx] == lo_tag);
            hi_hits[w] = valid_q[hi_idx][w] && (tag_q[w][hi_idx] == hi_tag);
            if (lo_hits[w]) begin
                lo_way  = WW'(w);
                lo_data = data_q[w][lo_idx];
            end
            if (hi_hits[w]) begin
                hi_way  = WW'(w);
                hi_data = data_q[w][hi_idx];
            end
        end
    end

    assign lo_hit    = |lo_hits;
    assign hi_ok     = !span || (|hi_hits);
    assign miss      = !lo_hit || !hi_ok;
    assign pair      = {hi_data, lo_data} >> {off, 3'b000};
    assign refilling = (state_q == REFILL_LO) || (state_q == REFILL_HI);
    assign refill_we = refilling && i_riscv_icache_mem_ack;
    assign hit_upd   = (state_q == IDLE) && !i_riscv_icache_flush && i_riscv_icache_req && !miss;
    assign vic       = victim(valid_q[r_idx], plru_q[r_idx]);

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        maddr_d = maddr_q;
        case (state_q)
            IDLE:
                if (i_riscv_icache_flush) state_d = FLUSH;
                else if (i_riscv_icache_req && !lo_hit) begin
                    state_d = REFILL_LO;
                    maddr_d = lo_b;
                end else if (i_riscv_icache_req && !hi_ok) begin
                    state_d = REFILL_HI;
                    maddr_d = hi_b;
                end
            REFILL_LO, REFILL_HI: begin
                pend_d = pend_q || i_riscv_icache_flush;
                if (i_riscv_icache_mem_ack) state_d = pend_d ? FLUSH : IDLE;
            end
            default: begin
                pend_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_riscv_icache_clk) begin
        if (refill_we) begin
            data_q[vic][r_idx] <= i_riscv_icache_mem_data;
            tag_q[vic][r_idx]  <= r_tag;
        end
    end

    always_ff @(posedge i_riscv_icache_clk) begin
        if (i_riscv_icache_rst || state_q == FLUSH) begin
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                plru_q[s]  <= '0;
            end
        end else if (refill_we) begin
            valid_q[r_idx][vic] <= 1'b1;
            plru_q[r_idx]       <= plru_touch(plru_q[r_idx], vic);
        end else if (hit_upd) begin
            plru_q[lo_idx] <= plru_touch(plru_q[lo_idx], lo_way);
            if (span) plru_q[hi_idx] <= plru_touch(plru_q[hi_idx], hi_way);
        end
    end

    always_ff @(posedge i_riscv_icache_clk) begin
        if (i_riscv_icache_rst) begin
            state_q <= IDLE;
            pend_q  <= 1'b0;
            maddr_q <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            maddr_q <= maddr_d;
        end
    end

    assign o_riscv_icache_stall    = i_riscv_icache_rst || (state_q != IDLE) ||
                                     (i_riscv_icache_req && (miss || i_riscv_icache_flush));
    assign o_riscv_icache_instr    = (o_riscv_icache_stall || !i_riscv_icache_req) ? 32'h0 : pair[31:0];
    assign o_riscv_icache_mem_req  = refilling;
    assign o_riscv_icache_mem_addr = maddr_q;
endmodule
